// File: rtl/ahb_pkg.sv
// Shared AHB definitions: transfer/response encodings, burst/size types,
// master count and the error-response FSM states.
package ahb_pkg;

  localparam int unsigned NUM_MASTERS  = 4;
  localparam int unsigned MASTER_IDX_W = 2;

  localparam logic [1:0] IDLE   = 2'b00;
  localparam logic [1:0] BUSY   = 2'b01;
  localparam logic [1:0] NONSEQ = 2'b10;
  localparam logic [1:0] SEQ    = 2'b11;

  localparam logic OKAY  = 1'b0;
  localparam logic ERROR = 1'b1;

  typedef logic [2:0] hburst_t;
  typedef logic [2:0] hsize_t;

  typedef enum logic {
    ST_OKAY = 1'b0,
    ST_ERR1 = 1'b1
  } err_state_t;

endpackage

// File: rtl/ahb_master_mux.sv
// Address/control mux keyed by HMASTER, write-data mux keyed by the data-phase
// owner, and cancellation of the owner's pending transfer on a two-cycle ERROR.
module ahb_master_mux
  import ahb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                              HCLK,
  input  logic                              HRESET,
  input  logic [1:0]                        HMASTER,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] HADDR_M,
  input  logic [NUM_MASTERS*2-1:0]          HTRANS_M,
  input  logic [NUM_MASTERS-1:0]            HWRITE_M,
  input  logic [NUM_MASTERS*3-1:0]          HSIZE_M,
  input  logic [NUM_MASTERS*3-1:0]          HBURST_M,
  input  logic [NUM_MASTERS*DATA_WIDTH-1:0] HWDATA_M,
  input  logic                              HREADY,
  input  logic                              HRESP,
  output logic [ADDR_WIDTH-1:0]             HADDR,
  output logic [1:0]                        HTRANS,
  output logic                              HWRITE,
  output logic [2:0]                        HSIZE,
  output logic [2:0]                        HBURST,
  output logic [DATA_WIDTH-1:0]             HWDATA,
  output logic [1:0]                        HMASTER_D,
  output logic                              DATA_ACTIVE,
  output logic [NUM_MASTERS-1:0]            HCANCEL
);

  logic [ADDR_WIDTH-1:0] haddr_a  [NUM_MASTERS];
  logic [1:0]            htrans_a [NUM_MASTERS];
  logic                  hwrite_a [NUM_MASTERS];
  hsize_t                hsize_a  [NUM_MASTERS];
  hburst_t               hburst_a [NUM_MASTERS];
  logic [DATA_WIDTH-1:0] hwdata_a [NUM_MASTERS];

  for (genvar g = 0; g < NUM_MASTERS; g++) begin : g_unpack
    assign haddr_a[g]  = HADDR_M[g*ADDR_WIDTH +: ADDR_WIDTH];
    assign htrans_a[g] = HTRANS_M[g*2 +: 2];
    assign hwrite_a[g] = HWRITE_M[g];
    assign hsize_a[g]  = HSIZE_M[g*3 +: 3];
    assign hburst_a[g] = HBURST_M[g*3 +: 3];
    assign hwdata_a[g] = HWDATA_M[g*DATA_WIDTH +: DATA_WIDTH];
  end

  err_state_t                err_state_q, err_state_d;
  logic [MASTER_IDX_W-1:0]   data_master_q, data_master_d;
  logic                      data_active_q, data_active_d;
  logic [1:0]                htrans_c;
  logic [NUM_MASTERS-1:0]    hcancel_c;

  // Pending address phase is suppressed while the second ERROR cycle is due.
  always_comb begin
    htrans_c = htrans_a[HMASTER];
    if (err_state_q == ST_ERR1) begin
      htrans_c = IDLE;
    end
  end

  assign HADDR       = haddr_a[HMASTER];
  assign HTRANS      = htrans_c;
  assign HWRITE      = hwrite_a[HMASTER];
  assign HSIZE       = hsize_a[HMASTER];
  assign HBURST      = hburst_a[HMASTER];
  assign HWDATA      = hwdata_a[data_master_q];
  assign HMASTER_D   = data_master_q;
  assign DATA_ACTIVE = data_active_q;
  assign HCANCEL     = hcancel_c;

  always_comb begin
    err_state_d   = err_state_q;
    data_master_d = data_master_q;
    data_active_d = data_active_q;
    hcancel_c     = '0;

    if (HREADY) begin
      data_master_d = HMASTER;
      data_active_d = htrans_c[1];
    end

    case (err_state_q)
      ST_OKAY: begin
        if ((HRESP == ERROR) && !HREADY && data_active_q) begin
          err_state_d = ST_ERR1;
        end
      end
      ST_ERR1: begin
        if (HREADY) begin
          err_state_d = ST_OKAY;
          // A reset landing on the final ERROR cycle must not emit a cancel.
          if ((htrans_a[HMASTER] != IDLE) && !HRESET) begin
            hcancel_c[HMASTER] = 1'b1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      err_state_q   <= ST_OKAY;
      data_master_q <= '0;
      data_active_q <= 1'b0;
    end else begin
      err_state_q   <= err_state_d;
      data_master_q <= data_master_d;
      data_active_q <= data_active_d;
    end
  end

endmodule

// File: tb/tb_ahb_master_mux.sv
// Bench for ahb_master_mux: directed scenarios plus random traffic against a
// behavioural model; data-phase expectations queued at each clock edge.
module tb_ahb_master_mux;
  import ahb_pkg::*;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  logic                 HCLK = 1'b0;
  logic                 HRESET;
  logic [1:0]           HMASTER;
  logic [4*AW-1:0]      HADDR_M;
  logic [7:0]           HTRANS_M;
  logic [3:0]           HWRITE_M;
  logic [11:0]          HSIZE_M;
  logic [11:0]          HBURST_M;
  logic [4*DW-1:0]      HWDATA_M;
  logic                 HREADY;
  logic                 HRESP;
  logic [AW-1:0]        HADDR;
  logic [1:0]           HTRANS;
  logic                 HWRITE;
  logic [2:0]           HSIZE;
  logic [2:0]           HBURST;
  logic [DW-1:0]        HWDATA;
  logic [1:0]           HMASTER_D;
  logic                 DATA_ACTIVE;
  logic [3:0]           HCANCEL;

  logic [AW-1:0] b_haddr  [4];
  logic [1:0]    b_htrans [4];
  logic          b_hwrite [4];
  logic [2:0]    b_hsize  [4];
  logic [2:0]    b_hburst [4];
  logic [DW-1:0] b_hwdata [4];

  always #5 HCLK = ~HCLK;

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      HADDR_M[i*AW +: AW]  = b_haddr[i];
      HTRANS_M[i*2 +: 2]   = b_htrans[i];
      HWRITE_M[i]          = b_hwrite[i];
      HSIZE_M[i*3 +: 3]    = b_hsize[i];
      HBURST_M[i*3 +: 3]   = b_hburst[i];
      HWDATA_M[i*DW +: DW] = b_hwdata[i];
    end
  end

  ahb_master_mux #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .HMASTER(HMASTER),
    .HADDR_M(HADDR_M), .HTRANS_M(HTRANS_M), .HWRITE_M(HWRITE_M),
    .HSIZE_M(HSIZE_M), .HBURST_M(HBURST_M), .HWDATA_M(HWDATA_M),
    .HREADY(HREADY), .HRESP(HRESP),
    .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE),
    .HBURST(HBURST), .HWDATA(HWDATA), .HMASTER_D(HMASTER_D),
    .DATA_ACTIVE(DATA_ACTIVE), .HCANCEL(HCANCEL)
  );

  typedef struct packed {
    logic [1:0] hmd;
    logic       da;
  } dexp_t;

  dexp_t sbq[$];
  int checks = 0;
  int errors = 0;

  logic [1:0] m_dm;
  logic       m_da;
  logic       m_err;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Compare every output against the model; registered values come off the queue.
  task automatic sample();
    logic [1:0] exp_ht;
    logic [3:0] exp_cn;
    dexp_t      d;
    #1;
    exp_ht = m_err ? IDLE : b_htrans[HMASTER];
    exp_cn = (m_err && HREADY && (b_htrans[HMASTER] != IDLE) && !HRESET)
             ? (4'b0001 << HMASTER) : 4'b0000;
    check_eq("haddr",   HADDR,          b_haddr[HMASTER]);
    check_eq("htrans",  32'(HTRANS),    32'(exp_ht));
    check_eq("hwrite",  32'(HWRITE),    32'(b_hwrite[HMASTER]));
    check_eq("hsize",   32'(HSIZE),     32'(b_hsize[HMASTER]));
    check_eq("hburst",  32'(HBURST),    32'(b_hburst[HMASTER]));
    check_eq("hcancel", 32'(HCANCEL),   32'(exp_cn));
    if (sbq.size() == 0) begin
      check_eq("sb_empty", 32'(sbq.size()), 32'd1);
    end else begin
      d = sbq.pop_front();
      check_eq("hmaster_d",   32'(HMASTER_D),   32'(d.hmd));
      check_eq("data_active", 32'(DATA_ACTIVE), 32'(d.da));
      check_eq("hwdata",      HWDATA,           b_hwdata[d.hmd]);
    end
  endtask

  task automatic edge_step();
    logic [1:0] ht;
    logic       nerr;
    dexp_t      d;
    @(posedge HCLK);
    ht = m_err ? IDLE : b_htrans[HMASTER];
    if (HRESET) begin
      m_dm = 2'd0; m_da = 1'b0; m_err = 1'b0;
    end else begin
      nerr = m_err ? !HREADY : (HRESP && !HREADY && m_da);
      if (HREADY) begin
        m_dm = HMASTER;
        m_da = ht[1];
      end
      m_err = nerr;
    end
    d.hmd = m_dm;
    d.da  = m_da;
    sbq.push_back(d);
    @(negedge HCLK);
  endtask

  task automatic set_trans(input logic [1:0] t);
    for (int i = 0; i < 4; i++) b_htrans[i] = t;
  endtask

  task automatic drive(input logic [1:0] hm, input logic [1:0] ht, input logic rdy, input logic rsp);
    HMASTER = hm;
    b_htrans[hm] = ht;
    HREADY = rdy;
    HRESP = rsp;
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin
      b_haddr[i]  = 32'h100 * 32'(i + 1);
      b_htrans[i] = IDLE;
      b_hwrite[i] = i[0];
      b_hsize[i]  = 3'(i);
      b_hburst[i] = 3'(i + 1);
      b_hwdata[i] = 32'hD000_0000 + 32'(i);
    end
    m_dm = 2'd0; m_da = 1'b0; m_err = 1'b0;
    HRESET = 1'b1; HMASTER = 2'd3; HREADY = 1'b1; HRESP = 1'b0;
    @(negedge HCLK);
    edge_step();

    // Reset held with arbitrary masters.
    for (int i = 0; i < 2; i++) begin
      HMASTER = 2'(i + 1);
      b_htrans[HMASTER] = NONSEQ;
      sample();
      check_eq("rst_hcancel", 32'(HCANCEL), 32'd0);
      edge_step();
    end
    check_eq("rst_hmd", 32'(HMASTER_D), 32'd0);
    check_eq("rst_da", 32'(DATA_ACTIVE), 32'd0);
    HRESET = 1'b0;
    set_trans(IDLE);

    // Basic write from master 2.
    b_haddr[2] = 32'h0000_1000;
    b_hwrite[2] = 1'b1;
    drive(2'd2, NONSEQ, 1'b1, 1'b0);
    sample();
    check_eq("basic_haddr", HADDR, 32'h0000_1000);
    edge_step();
    drive(2'd2, NONSEQ, 1'b1, 1'b0);
    sample();
    check_eq("basic_hmd", 32'(HMASTER_D), 32'd2);
    check_eq("basic_da", 32'(DATA_ACTIVE), 32'd1);
    check_eq("basic_hwdata", HWDATA, 32'hD000_0002);
    edge_step();

    // Wait states while the address owner moves 1 -> 3.
    for (int i = 1; i <= 3; i++) begin
      drive(2'(i), NONSEQ, 1'b0, 1'b0);
      sample();
      check_eq("wait_hmd", 32'(HMASTER_D), 32'd2);
      check_eq("wait_hwdata", HWDATA, 32'hD000_0002);
      edge_step();
    end
    drive(2'd3, NONSEQ, 1'b1, 1'b0);
    sample();
    edge_step();
    check_eq("wait_release_hmd", 32'(HMASTER_D), 32'd3);
    set_trans(IDLE);

    // Master 0 INCR4 then handover to master 1.
    b_hburst[0] = 3'b011;
    for (int i = 0; i < 4; i++) begin
      drive(2'd0, (i == 0) ? NONSEQ : SEQ, 1'b1, 1'b0);
      sample();
      edge_step();
    end
    b_htrans[0] = IDLE;
    drive(2'd1, NONSEQ, 1'b1, 1'b0);
    sample();
    check_eq("ho_hwdata_m0", HWDATA, 32'hD000_0000);
    edge_step();
    drive(2'd1, IDLE, 1'b1, 1'b0);
    sample();
    check_eq("ho_hwdata_m1", HWDATA, 32'hD000_0001);
    edge_step();

    // Two-cycle ERROR on master 3's data phase.
    drive(2'd3, NONSEQ, 1'b1, 1'b0);
    sample();
    edge_step();
    drive(2'd3, SEQ, 1'b0, 1'b1);
    sample();
    check_eq("err1_htrans", 32'(HTRANS), 32'(SEQ));
    edge_step();
    drive(2'd3, SEQ, 1'b1, 1'b1);
    sample();
    check_eq("err2_htrans", 32'(HTRANS), 32'(IDLE));
    check_eq("err2_hcancel", 32'(HCANCEL), 32'b1000);
    edge_step();
    drive(2'd3, IDLE, 1'b1, 1'b0);
    sample();
    check_eq("err_after_da", 32'(DATA_ACTIVE), 32'd0);
    edge_step();

    // Spurious ERROR with no active data phase.
    drive(2'd1, NONSEQ, 1'b0, 1'b1);
    sample();
    check_eq("spur_htrans", 32'(HTRANS), 32'(NONSEQ));
    edge_step();
    drive(2'd1, NONSEQ, 1'b1, 1'b0);
    sample();
    check_eq("spur_htrans2", 32'(HTRANS), 32'(NONSEQ));
    check_eq("spur_hcancel", 32'(HCANCEL), 32'd0);
    edge_step();

    // Handover coinciding with the final ERROR cycle.
    drive(2'd1, SEQ, 1'b0, 1'b1);
    sample();
    edge_step();
    drive(2'd0, NONSEQ, 1'b1, 1'b1);
    sample();
    check_eq("hoerr_hcancel", 32'(HCANCEL), 32'b0001);
    edge_step();
    set_trans(IDLE);
    drive(2'd0, IDLE, 1'b1, 1'b0);
    sample();
    check_eq("hoerr_hmd", 32'(HMASTER_D), 32'd0);
    check_eq("hoerr_da", 32'(DATA_ACTIVE), 32'd0);
    edge_step();

    // Reset arriving during ERR1.
    drive(2'd2, NONSEQ, 1'b1, 1'b0);
    sample();
    edge_step();
    drive(2'd2, NONSEQ, 1'b0, 1'b1);
    sample();
    edge_step();
    HRESET = 1'b1;
    drive(2'd2, NONSEQ, 1'b1, 1'b1);
    sample();
    check_eq("rsterr_hcancel", 32'(HCANCEL), 32'd0);
    edge_step();
    HRESET = 1'b0;
    drive(2'd2, NONSEQ, 1'b1, 1'b0);
    sample();
    check_eq("rsterr_htrans", 32'(HTRANS), 32'(NONSEQ));
    edge_step();

    // Random traffic.
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < 4; i++) begin
        b_haddr[i]  = $urandom;
        b_hwdata[i] = $urandom;
        b_hwrite[i] = 1'($urandom_range(0, 1));
        b_hsize[i]  = 3'($urandom_range(0, 7));
        b_hburst[i] = 3'($urandom_range(0, 7));
        case ($urandom_range(0, 3))
          0:       b_htrans[i] = IDLE;
          1:       b_htrans[i] = BUSY;
          2:       b_htrans[i] = NONSEQ;
          default: b_htrans[i] = SEQ;
        endcase
      end
      HMASTER = 2'($urandom_range(0, 3));
      HREADY  = ($urandom_range(0, 3) != 0);
      HRESP   = ($urandom_range(0, 5) == 0);
      HRESET  = ($urandom_range(0, 59) == 0);
      sample();
      edge_step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
